// File: rtl/i2s_pkg.sv
// Constants shared by the I2S receiver, transmitter and sample FIFO.
package i2s_pkg;
   localparam int SAMPLE_W = 16;
   localparam int FRAME_BITS = 64;
   localparam int POSN_W = $clog2(FRAME_BITS);
   localparam logic [POSN_W-1:0] FRAME_START = '0;
   localparam int STEREO_W = 2 * SAMPLE_W;
endpackage

// File: rtl/i2s_frame_strobe.sv
// Detects sck rising edges in the ck domain and pulses strobe for one ck cycle
// when that edge lands on the first bit of a frame.
module i2s_frame_strobe
   import i2s_pkg::*;
(
   input  logic              ck,
   input  logic              rst_n,
   input  logic              sck,
   input  logic [POSN_W-1:0] frame_posn,
   output logic              strobe
);

   logic sck_q, sck_d;

   always_comb sck_d = sck;

   // History resets low so a rising edge right after reset release is seen.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) sck_q <= 1'b0;
      else        sck_q <= sck_d;
   end

   assign strobe = sck & ~sck_q & (frame_posn == FRAME_START);

endmodule

// File: rtl/i2s_fifo.sv
// Stereo sample FIFO between the I2S receiver and a ready/valid consumer.
// Define I2S_FIFO_DROP_CNT_EN to build the saturating dropped-sample counter.
module i2s_fifo
   import i2s_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = SAMPLE_W
) (
   input  logic                       ck,
   input  logic                       rst_n,
   input  logic                       sck,
   input  logic [POSN_W-1:0]          frame_posn,
   input  logic [WIDTH-1:0]           left,
   input  logic [WIDTH-1:0]           right,
   output logic [2*WIDTH-1:0]         out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clr_ovf,
   output logic [15:0]                drop_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               strobe, empty, full, pop, push, drop;

   i2s_frame_strobe u_strobe (
      .ck         (ck),
      .rst_n      (rst_n),
      .sck        (sck),
      .frame_posn (frame_posn),
      .strobe     (strobe)
   );

   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == FULL_LVL);
      pop      = !empty && out_ready;
      // A pop on the same edge frees the slot, so a full FIFO still accepts.
      push     = strobe && (!full || pop);
      drop     = strobe && full && !pop;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; validity is tracked entirely by level.
   always_ff @(posedge ck) begin
      if (push) mem_q[wr_ptr_q] <= {left, right};
   end

   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign level     = level_q;
   assign overflow  = ovf_q;

`ifdef I2S_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clr_ovf) drop_cnt_d = '0;
      if (drop) begin
         if (clr_ovf)                     drop_cnt_d = 16'd1;
         else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_i2s_fifo.sv
// Directed bench for i2s_fifo: vector table plus multi-cycle corner sequences.
module tb_i2s_fifo;

   logic        ck = 1'b0;
   logic        rst_n = 1'b0;
   logic        sck = 1'b0;
   logic [5:0]  frame_posn = '0;
   logic [15:0] left = '0, right = '0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  level;
   logic        overflow;
   logic        clr_ovf = 1'b0;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;

`ifdef I2S_FIFO_DROP_CNT_EN
   localparam bit DC_ON = 1'b1;
`else
   localparam bit DC_ON = 1'b0;
`endif

   i2s_fifo #(.DEPTH(16), .WIDTH(16)) dut (
      .ck         (ck),
      .rst_n      (rst_n),
      .sck        (sck),
      .frame_posn (frame_posn),
      .left       (left),
      .right      (right),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf),
      .drop_count (drop_count)
   );

   always #5 ck = ~ck;

   typedef struct {
      logic        stb;
      logic [5:0]  posn;
      logic [15:0] l;
      logic [15:0] r;
      logic        rdy;
      logic        clr;
      logic        e_valid;
      logic [31:0] e_data;
      logic [4:0]  e_level;
      logic        e_ovf;
   } vec_t;

   vec_t tbl [9];

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dc(input int n);
      return DC_ON ? 32'(n) : 32'd0;
   endfunction

   // One low sck cycle (no pop), then one edge carrying the given inputs.
   task automatic step(input logic stb, input logic [5:0] posn, input logic [15:0] l,
                       input logic [15:0] r, input logic rdy, input logic clr);
      sck = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; frame_posn = '0;
      tick();
      frame_posn = posn; left = l; right = r; out_ready = rdy; clr_ovf = clr; sck = stb;
      tick();
      sck = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; frame_posn = '0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int vcnt;
      int exp_lvl;

      tbl[0] = '{1'b1, 6'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 32'h11112222, 5'd1, 1'b0};
      tbl[1] = '{1'b1, 6'd0, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, 32'h11112222, 5'd2, 1'b0};
      tbl[2] = '{1'b0, 6'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h33334444, 5'd1, 1'b0};
      tbl[3] = '{1'b1, 6'd0, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b1, 32'h55556666, 5'd1, 1'b0};
      tbl[4] = '{1'b0, 6'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
      tbl[5] = '{1'b0, 6'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h00000000, 5'd0, 1'b0};
      tbl[6] = '{1'b1, 6'd5, 16'h7777, 16'h7777, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};
      tbl[7] = '{1'b1, 6'd0, 16'h8234, 16'h8235, 1'b0, 1'b0, 1'b1, 32'h82348235, 5'd1, 1'b0};
      tbl[8] = '{1'b0, 6'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0};

      // reset state
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].stb, tbl[i].posn, tbl[i].l, tbl[i].r, tbl[i].rdy, tbl[i].clr);
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
         check($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
         check($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].e_level));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      end

      // Free-running I2S bit clock, two frames, consumer always ready
      left = 16'h8234; right = 16'h8235; out_ready = 1'b1; vcnt = 0;
      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < 64; b++) begin
            sck = 1'b0; frame_posn = 6'(b);
            tick(); vcnt += int'(out_valid);
            tick(); vcnt += int'(out_valid);
            sck = 1'b1;
            tick(); vcnt += int'(out_valid);
            if (b == 0) begin
               check("i2s_valid", 32'(out_valid), 32'd1);
               check("i2s_data", out_data, 32'h82348235);
            end
            tick(); vcnt += int'(out_valid);
         end
      end
      sck = 1'b0; out_ready = 1'b0; frame_posn = '0;
      tick();
      check("i2s_valid_cycles", 32'(vcnt), 32'd2);
      check("i2s_level", 32'(level), 32'd0);

      // Fill past full: 16 stored, 4 dropped
      for (int i = 0; i < 20; i++) step(1'b1, 6'd0, 16'(i), 16'(i + 100), 1'b0, 1'b0);
      check("fill_level", 32'(level), 32'd16);
      check("fill_ovf", 32'(overflow), 32'd1);
      check("fill_drop", 32'(drop_count), dc(4));
      check("fill_head", out_data, {16'd0, 16'd100});
      step(1'b0, 6'd0, 16'h0, 16'h0, 1'b0, 1'b1);
      check("clr_ovf", 32'(overflow), 32'd0);
      check("clr_drop", 32'(drop_count), 32'd0);

      // Strobe and pop on the same edge while full
      step(1'b1, 6'd0, 16'hAAAA, 16'hBBBB, 1'b1, 1'b0);
      check("fullpp_level", 32'(level), 32'd16);
      check("fullpp_ovf", 32'(overflow), 32'd0);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("drain%0d", k), out_data,
               (k < 15) ? {16'(k + 1), 16'(k + 101)} : 32'hAAAABBBB);
         pop_one();
      end
      check("drain_level", 32'(level), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd0);

      // clr_ovf colliding with a drop
      for (int i = 0; i < 16; i++) step(1'b1, 6'd0, 16'(i + 200), 16'h0, 1'b0, 1'b0);
      check("refill_ovf", 32'(overflow), 32'd0);
      step(1'b1, 6'd0, 16'h1, 16'h1, 1'b0, 1'b0);
      step(1'b1, 6'd0, 16'h1, 16'h1, 1'b0, 1'b0);
      check("drop2_cnt", 32'(drop_count), dc(2));
      step(1'b1, 6'd0, 16'h1, 16'h1, 1'b0, 1'b1);
      check("clrdrop_ovf", 32'(overflow), 32'd1);
      check("clrdrop_cnt", 32'(drop_count), dc(1));
      check("clrdrop_head", out_data, {16'd200, 16'd0});

      // Asynchronous reset mid-frame with five entries held
      for (int k = 0; k < 11; k++) pop_one();
      check("pre_rst_level", 32'(level), 32'd5);
      sck = 1'b1; frame_posn = 6'd10;
      #3 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", out_data, 32'd0);
      check("arst_level", 32'(level), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      check("arst_drop", 32'(drop_count), 32'd0);
      tick(); tick();
      sck = 1'b0;
      rst_n = 1'b1;
      frame_posn = 6'd0; left = 16'hCAFE; right = 16'hF00D; sck = 1'b1;
      tick();
      check("post_rst_level", 32'(level), 32'd1);
      check("post_rst_data", out_data, 32'hCAFEF00D);
      sck = 1'b0;
      tick();
      pop_one();

      // frame_posn pinned at 0: exactly one capture per sck rising edge
      exp_lvl = 0;
      for (int p = 0; p < 5; p++) begin
         sck = 1'b1;
         tick(); exp_lvl++;
         check($sformatf("pin%0d_a", p), 32'(level), 32'(exp_lvl));
         tick();
         check($sformatf("pin%0d_b", p), 32'(level), 32'(exp_lvl));
         sck = 1'b0;
         tick();
         check($sformatf("pin%0d_c", p), 32'(level), 32'(exp_lvl));
         tick();
         check($sformatf("pin%0d_d", p), 32'(level), 32'(exp_lvl));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
